alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, registered successor to the processor's combinational ALU. It adds a START/DONE handshake, add/subtract with carry/borrow, and a multi-cycle shift-add multiply. It also registers the ZERO and PARITY flags. It sits between the register file read ports and the writeback mux, and the controller stalls on BUSY.

## Interface
Parameters:
- W, default 8: operand and result width; legal W >= 2.
- CW, default $clog2(W)+1: multiply iteration counter width (derived; do not override).

Ports:
- Clk, input, 1: clock; all state updates on the rising edge.
- Reset_n, input, 1: synchronous, active-low reset.
- START, input, 1: request; sampled only when BUSY=0.
- OP, input, 3: opcode, captured with START.
- INPUTA, input, W: operand A, captured with START.
- INPUTB, input, W: operand B, captured with START.
- SC_IN, input, 1: shift-in / carry-in, captured with START.
- BUSY, output, 1: operation in flight; START is ignored while high.
- DONE, output, 1: one-cycle pulse; the result outputs are valid from this cycle onward.
- OUT, output, W: registered result.
- SC_OUT, output, 1: registered shift-out, carry, borrow or overflow.
- ZERO, output, 1: registered; equals (OUT == 0).
- PARITY, output, 1: registered; equals ^OUT (0 = even number of ones, 1 = odd).

## Operation
Opcodes:
- 000 AND: OUT = A & B; SC_OUT = 0.
- 001 LSH: {SC_OUT, OUT} = {A, SC_IN}.
- 010 RSH: {OUT, SC_OUT} = {SC_IN, A}.
- 011 XOR: OUT = A ^ B; SC_OUT = 0.
- 100 ADD: {SC_OUT, OUT} = A + B + SC_IN, computed at W+1 bits.
- 101 SUB: OUT = A - B mod 2^W; SC_OUT = 1 when A < B (unsigned borrow). SC_IN is ignored.
- 110 MUL: unsigned product. OUT = low W bits; SC_OUT = 1 when the high W bits are nonzero. SC_IN is ignored.
- 111 NOP: OUT = 0; SC_OUT = 0. It still completes with DONE, ZERO=1 and PARITY=0.

State machine:
- IDLE: START=1 captures OP/A/B/SC_IN.
  - Non-MUL ops compute from the captured values, write the outputs, pulse DONE, and stay in IDLE.
  - MUL loads the multiplicand, multiplier and a 2W-bit accumulator, sets count to 0 and BUSY=1, and goes to MULT.
- MULT: each edge does one step. If multiplier[0]=1, add the multiplicand << count to the accumulator. Then shift the multiplier right by 1 and increment count.
  - On the edge where count reaches W-1 (the W-th iteration), write OUT/SC_OUT/ZERO/PARITY from the final accumulator, pulse DONE, clear BUSY, and go to IDLE.
- ZERO and PARITY are always computed from the value being written into OUT, so they are never stale relative to OUT.
- OUT, SC_OUT, ZERO and PARITY hold their values until the next completion. A START that is ignored does not change them.

## Timing
- Reset (Reset_n=0 at an edge): state=IDLE. OUT=0, SC_OUT=0, ZERO=0, PARITY=0, BUSY=0, DONE=0. The accumulator and counter are cleared.
- Non-MUL latency: START accepted at edge k gives DONE=1 and valid outputs in cycle k+1. BUSY stays 0.
- MUL latency: START accepted at edge k gives BUSY=1 from cycle k+1 through cycle k+W. DONE=1 and valid outputs appear in cycle k+W+1, with BUSY=0 in that cycle.
- DONE is high for exactly one cycle per accepted START.
- Back-to-back: START may be high in the same cycle as DONE; it is accepted because BUSY=0. Non-MUL ops sustain one result per cycle.
- START while BUSY=1 is dropped, not queued. Operand changes during MULT have no effect.
- Reset mid-MULT aborts the operation: no DONE is issued and the outputs go to their reset values.
- Reset and START in the same edge: reset wins.

## Test plan
- Reset, then W=8, AND 0xF0 & 0x3C: cycle after START shows OUT=0x30, SC_OUT=0, ZERO=0, PARITY=0, DONE=1 for one cycle, BUSY=0 throughout.
- ADD 0xFF + 0x01, SC_IN=0: OUT=0x00, SC_OUT=1, ZERO=1, PARITY=0.
- ADD 0x7F + 0x00, SC_IN=1: OUT=0x80, SC_OUT=0, PARITY=1.
- SUB 0x05 - 0x07: OUT=0xFE, SC_OUT=1, PARITY=1.
- LSH 0x81, SC_IN=1: OUT=0x03, SC_OUT=1.
- RSH 0x81, SC_IN=0: OUT=0x40, SC_OUT=1.
- MUL 13 x 11: BUSY high for 8 cycles, then OUT=0x8F, SC_OUT=0, DONE at cycle k+9. MUL 20 x 20: OUT=0x90, SC_OUT=1.
- Extra START (XOR) pulsed while BUSY during a MUL: ignored; exactly one DONE is seen, carrying the MUL result.
- START XOR 0xAA ^ 0x55 held high in the DONE cycle of a MUL: the next cycle gives DONE again with OUT=0xFF, PARITY=0.
- Reset_n driven low at MULT iteration 4: no DONE, all outputs 0. The next MUL 3 x 3 gives OUT=0x09.
- Parametrised run with W=16: MUL 0x0100 x 0x0100 gives OUT=0x0000, SC_OUT=1, ZERO=1, DONE 17 cycles after the START edge.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/result bundle between the controller and alu_seq.
// The controller drives START/OP/operands; the ALU returns status and registered results.
interface alu_seq_if #(
    parameter int W = 8
);
    logic         START;
    logic [2:0]   OP;
    logic [W-1:0] INPUTA;
    logic [W-1:0] INPUTB;
    logic         SC_IN;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] OUT;
    logic         SC_OUT;
    logic         ZERO;
    logic         PARITY;

    modport master (
        output START, OP, INPUTA, INPUTB, SC_IN,
        input  BUSY, DONE, OUT, SC_OUT, ZERO, PARITY
    );

    modport slave (
        input  START, OP, INPUTA, INPUTB, SC_IN,
        output BUSY, DONE, OUT, SC_OUT, ZERO, PARITY
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with START/DONE handshake; single-cycle logic ops and add/sub,
// plus a W-iteration shift-add multiplier that holds BUSY while it runs.
module alu_seq #(
    parameter int W  = 8,
    parameter int CW = $clog2(W) + 1
) (
    input  logic      Clk,
    input  logic      Reset_n,
    alu_seq_if.slave  bus
);
    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_LSH = 3'b001;
    localparam logic [2:0] OP_RSH = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MULT = 1'b1} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_out;
    logic           r_sc;
    logic           r_zero;
    logic           r_par;
    logic           r_done;
    logic           r_busy;

    logic [W:0]     w_add;
    logic [W:0]     w_sub;
    logic [W-1:0]   w_alu_out;
    logic           w_alu_sc;
    logic [2*W-1:0] w_addend;
    logic [2*W-1:0] w_acc_nxt;
    logic           w_last;
    logic           w_load;
    logic           w_mul_go;
    logic [W-1:0]   w_res;
    logic           w_res_sc;

    function automatic logic parity_f(input logic [W-1:0] v);
        return ^v;
    endfunction

    // Single-cycle datapath; SUB borrow falls out of the (W+1)-bit wrap.
    always_comb begin
        w_add = {1'b0, bus.INPUTA} + {1'b0, bus.INPUTB} + {{W{1'b0}}, bus.SC_IN};
        w_sub = {1'b0, bus.INPUTA} - {1'b0, bus.INPUTB};
        case (bus.OP)
            OP_AND: begin w_alu_out = bus.INPUTA & bus.INPUTB;             w_alu_sc = 1'b0;              end
            OP_LSH: begin w_alu_out = {bus.INPUTA[W-2:0], bus.SC_IN};     w_alu_sc = bus.INPUTA[W-1];   end
            OP_RSH: begin w_alu_out = {bus.SC_IN, bus.INPUTA[W-1:1]};     w_alu_sc = bus.INPUTA[0];     end
            OP_XOR: begin w_alu_out = bus.INPUTA ^ bus.INPUTB;             w_alu_sc = 1'b0;              end
            OP_ADD: begin w_alu_out = w_add[W-1:0];                        w_alu_sc = w_add[W];          end
            OP_SUB: begin w_alu_out = w_sub[W-1:0];                        w_alu_sc = w_sub[W];          end
            default: begin w_alu_out = {W{1'b0}};                          w_alu_sc = 1'b0;              end
        endcase
    end

    // One shift-add step of the multiplier.
    always_comb begin
        if (r_mplier[0]) begin
            w_addend = {{W{1'b0}}, r_mcand} << r_count;
        end else begin
            w_addend = {(2*W){1'b0}};
        end
        w_acc_nxt = r_acc + w_addend;
        w_last    = (r_count == CW'(W - 1));
    end

    // Next-state and result-select logic.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_mul_go    = 1'b0;
        w_res       = {W{1'b0}};
        w_res_sc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    if (bus.OP == OP_MUL) begin
                        w_state_nxt = S_MULT;
                        w_mul_go    = 1'b1;
                    end else begin
                        w_load   = 1'b1;
                        w_res    = w_alu_out;
                        w_res_sc = w_alu_sc;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MULT: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_load      = 1'b1;
                    w_res       = w_acc_nxt[W-1:0];
                    w_res_sc    = |w_acc_nxt[2*W-1:W];
                end else begin
                    w_state_nxt = S_MULT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Multiplier operand, accumulator and iteration counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_mcand  <= {W{1'b0}};
            r_mplier <= {W{1'b0}};
            r_acc    <= {(2*W){1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (w_mul_go) begin
            r_mcand  <= bus.INPUTA;
            r_mplier <= bus.INPUTB;
            r_acc    <= {(2*W){1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (r_state == S_MULT) begin
            r_acc    <= w_acc_nxt;
            r_mplier <= {1'b0, r_mplier[W-1:1]};
            r_count  <= r_count + CW'(1);
        end
    end

    // Result registers: flags derive from the value being written so they track OUT.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_out  <= {W{1'b0}};
            r_sc   <= 1'b0;
            r_zero <= 1'b0;
            r_par  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_done <= w_load;
            r_busy <= (w_state_nxt == S_MULT);
            if (w_load) begin
                r_out  <= w_res;
                r_sc   <= w_res_sc;
                r_zero <= (w_res == {W{1'b0}});
                r_par  <= parity_f(w_res);
            end
        end
    end

    assign bus.OUT    = r_out;
    assign bus.SC_OUT = r_sc;
    assign bus.ZERO   = r_zero;
    assign bus.PARITY = r_par;
    assign bus.DONE   = r_done;
    assign bus.BUSY   = r_busy;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: a transaction-level model checked every cycle,
// plus directed vectors with hand-computed results for W=8 and W=16.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_seq_if #(.W(8))  bus8  ();
    alu_seq_if #(.W(16)) bus16 ();

    alu_seq #(.W(8))  dut8  (.Clk(clk), .Reset_n(rst_n), .bus(bus8.slave));
    alu_seq #(.W(16)) dut16 (.Clk(clk), .Reset_n(rst_n), .bus(bus16.slave));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model of the W=8 instance ----------------
    logic [7:0] m_out, pend_out;
    logic       m_sc, m_zero, m_par, m_done, m_busy, pend_sc;
    int         m_left;

    task automatic publish(input logic [7:0] o, input logic s);
        m_out  = o;
        m_sc   = s;
        m_zero = (o == 8'd0);
        m_par  = (($countones(o) % 2) == 1);
        m_done = 1'b1;
    endtask

    initial begin
        int ia, ib, r;
        m_out = 8'd0; m_sc = 1'b0; m_zero = 1'b0; m_par = 1'b0;
        m_done = 1'b0; m_busy = 1'b0; m_left = 0; pend_out = 8'd0; pend_sc = 1'b0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_out = 8'd0; m_sc = 1'b0; m_zero = 1'b0; m_par = 1'b0;
                m_done = 1'b0; m_busy = 1'b0; m_left = 0;
            end else begin
                m_done = 1'b0;
                ia = int'(bus8.INPUTA);
                ib = int'(bus8.INPUTB);
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        publish(pend_out, pend_sc);
                        m_busy = 1'b0;
                    end
                end else if (bus8.START) begin
                    case (bus8.OP)
                        3'd0: publish(bus8.INPUTA & bus8.INPUTB, 1'b0);
                        3'd1: begin r = ia * 2 + int'(bus8.SC_IN);   publish(8'(r), 1'(r / 256)); end
                        3'd2: begin r = int'(bus8.SC_IN) * 256 + ia; publish(8'(r / 2), 1'(r % 2)); end
                        3'd3: publish(bus8.INPUTA ^ bus8.INPUTB, 1'b0);
                        3'd4: begin r = ia + ib + int'(bus8.SC_IN);  publish(8'(r), 1'(r / 256)); end
                        3'd5: publish(8'(ia - ib), ia < ib);
                        3'd6: begin
                            r = ia * ib;
                            pend_out = 8'(r);
                            pend_sc  = (r / 256) != 0;
                            m_left   = 8;
                            m_busy   = 1'b1;
                        end
                        default: publish(8'd0, 1'b0);
                    endcase
                end
            end
        end
    end

    // Every-cycle comparison of the W=8 instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_out",  {24'd0, bus8.OUT}, {24'd0, m_out});
                check("cyc_sc",   {31'd0, bus8.SC_OUT}, {31'd0, m_sc});
                check("cyc_zero", {31'd0, bus8.ZERO},   {31'd0, m_zero});
                check("cyc_par",  {31'd0, bus8.PARITY}, {31'd0, m_par});
                check("cyc_done", {31'd0, bus8.DONE},   {31'd0, m_done});
                check("cyc_busy", {31'd0, bus8.BUSY},   {31'd0, m_busy});
            end
        end
    end

    // ---------------- directed helpers (entered and left at a negedge) ----------------
    task automatic run_op(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] eo, input logic es, input logic ez,
                          input logic ep, input int elat);
        int lat = 0;
        int nb  = 0;
        bus8.START = 1'b1; bus8.OP = op; bus8.INPUTA = a; bus8.INPUTB = b; bus8.SC_IN = cin;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bus8.START = 1'b0;
            if (bus8.BUSY) nb++;
            if (bus8.DONE) begin
                lat = i;
                break;
            end
        end
        check({nm, "_lat"},  lat, elat);
        check({nm, "_busy"}, nb, elat - 1);
        check({nm, "_out"},  {24'd0, bus8.OUT}, {24'd0, eo});
        check({nm, "_sc"},   {31'd0, bus8.SC_OUT}, {31'd0, es});
        check({nm, "_zero"}, {31'd0, bus8.ZERO},   {31'd0, ez});
        check({nm, "_par"},  {31'd0, bus8.PARITY}, {31'd0, ep});
        @(negedge clk);
        check({nm, "_done1"}, {31'd0, bus8.DONE}, 32'd0);
    endtask

    task automatic run16(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eo, input logic es, input logic ez, input int elat);
        int lat = 0;
        bus16.START = 1'b1; bus16.OP = op; bus16.INPUTA = a; bus16.INPUTB = b; bus16.SC_IN = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            bus16.START = 1'b0;
            if (bus16.DONE) begin
                lat = i;
                break;
            end
        end
        check({nm, "_lat"},  lat, elat);
        check({nm, "_out"},  {16'd0, bus16.OUT}, {16'd0, eo});
        check({nm, "_sc"},   {31'd0, bus16.SC_OUT}, {31'd0, es});
        check({nm, "_zero"}, {31'd0, bus16.ZERO},   {31'd0, ez});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int nd;
        logic [7:0] o_seen;
        rst_n = 1'b0;
        bus8.START = 1'b0;  bus8.OP = 3'd0;  bus8.INPUTA = 8'd0;  bus8.INPUTB = 8'd0;  bus8.SC_IN = 1'b0;
        bus16.START = 1'b0; bus16.OP = 3'd0; bus16.INPUTA = 16'd0; bus16.INPUTB = 16'd0; bus16.SC_IN = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out",  {24'd0, bus8.OUT}, 32'd0);
        check("rst_sc",   {31'd0, bus8.SC_OUT}, 32'd0);
        check("rst_zero", {31'd0, bus8.ZERO},   32'd0);
        check("rst_par",  {31'd0, bus8.PARITY}, 32'd0);
        check("rst_busy", {31'd0, bus8.BUSY},   32'd0);
        check("rst_done", {31'd0, bus8.DONE},   32'd0);
        check("rst16_zero", {31'd0, bus16.ZERO}, 32'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);

        run_op("and",   3'd0, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1);
        run_op("add1",  3'd4, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1);
        run_op("add2",  3'd4, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1);
        run_op("sub",   3'd5, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1, 1);
        run_op("lsh",   3'd1, 8'h81, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1);
        run_op("rsh",   3'd2, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0, 1'b1, 1);
        run_op("nop",   3'd7, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1);
        run_op("mul1",  3'd6, 8'd13, 8'd11, 1'b1, 8'h8F, 1'b0, 1'b0, 1'b1, 9);
        run_op("mul2",  3'd6, 8'd20, 8'd20, 1'b0, 8'h90, 1'b1, 1'b0, 1'b0, 9);

        // XOR pulsed while the multiplier is busy is dropped; operands also change mid-run.
        nd = 0; o_seen = 8'h00;
        bus8.START = 1'b1; bus8.OP = 3'd6; bus8.INPUTA = 8'd13; bus8.INPUTB = 8'd11;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 3) begin
                bus8.START = 1'b1; bus8.OP = 3'd3; bus8.INPUTA = 8'hAA; bus8.INPUTB = 8'h55;
            end else begin
                bus8.START = 1'b0;
            end
            if (bus8.DONE) begin
                nd++;
                o_seen = bus8.OUT;
            end
        end
        check("busy_drop_ndone", nd, 1);
        check("busy_drop_out", {24'd0, o_seen}, 32'h8F);

        // START held in the DONE cycle of a MUL is accepted.
        nd = 0;
        bus8.START = 1'b1; bus8.OP = 3'd6; bus8.INPUTA = 8'hFF; bus8.INPUTB = 8'hFF;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus8.START = 1'b0;
            if (bus8.DONE) begin
                nd = i;
                break;
            end
        end
        check("b2b_mul_lat", nd, 9);
        check("b2b_mul_out", {24'd0, bus8.OUT}, 32'h01);
        check("b2b_mul_sc",  {31'd0, bus8.SC_OUT}, 32'd1);
        bus8.START = 1'b1; bus8.OP = 3'd3; bus8.INPUTA = 8'hAA; bus8.INPUTB = 8'h55;
        @(negedge clk);
        bus8.START = 1'b0;
        check("b2b_xor_done", {31'd0, bus8.DONE}, 32'd1);
        check("b2b_xor_out",  {24'd0, bus8.OUT}, 32'hFF);
        check("b2b_xor_par",  {31'd0, bus8.PARITY}, 32'd0);
        @(negedge clk);

        // Reset during the multiply aborts it.
        bus8.START = 1'b1; bus8.OP = 3'd6; bus8.INPUTA = 8'd13; bus8.INPUTB = 8'd11;
        repeat (3) begin
            @(negedge clk);
            bus8.START = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_out",  {24'd0, bus8.OUT}, 32'd0);
        check("abort_busy", {31'd0, bus8.BUSY}, 32'd0);
        check("abort_zero", {31'd0, bus8.ZERO}, 32'd0);
        nd = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus8.DONE) nd++;
        end
        check("abort_ndone", nd, 0);
        run_op("mul3",  3'd6, 8'd3, 8'd3, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0, 9);

        // Reset and START on the same edge: reset wins.
        rst_n = 1'b0;
        bus8.START = 1'b1; bus8.OP = 3'd4; bus8.INPUTA = 8'd1; bus8.INPUTB = 8'd1;
        @(negedge clk);
        rst_n = 1'b1; bus8.START = 1'b0;
        check("rst_win_done", {31'd0, bus8.DONE}, 32'd0);
        check("rst_win_out",  {24'd0, bus8.OUT}, 32'd0);
        @(negedge clk);

        run16("w16_mul", 3'd6, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b1, 17);
        run16("w16_sub", 3'd5, 16'h1234, 16'h1235, 16'hFFFF, 1'b1, 1'b0, 1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
